// File: rtl/axi_dac_jesd204_pkg.sv
// axi_dac_jesd204_pkg
//   Shared definitions for the JESD204 DAC start/stop sequencer:
//   the state-register width and the FSM state encodings.
//   No ports (package).
package axi_dac_jesd204_pkg;

  localparam int SEQ_STATE_W = 3;

  // Encodings 5-7 are unused; the FSM recovers from them to IDLE.
  typedef enum logic [SEQ_STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_ALIGN = 3'd2,
    ST_DELAY = 3'd3,
    ST_RUN   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/axi_dac_jesd204_tx_sequencer_if.sv
// axi_dac_jesd204_tx_sequencer_if
//   DMA sample stream into the DAC sequencer.
//   valid : source has a beat on data this cycle
//   data  : DW-bit packed samples, channel i in lane i
//   ready : sink consumes data this cycle
//   Modports: master = DMA side, slave = sequencer side.
interface axi_dac_jesd204_tx_sequencer_if #(
  parameter int DW = 64
);
  logic          valid;
  logic [DW-1:0] data;
  logic          ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/axi_dac_jesd204_sat_cnt.sv
// axi_dac_jesd204_sat_cnt
//   Saturating up-counter with synchronous clear.
//   clk   : clock
//   srst  : synchronous active-high reset (count -> 0)
//   clr   : clear; when asserted together with inc the count becomes 1
//   inc   : increment by one, holding at all-ones
//   count : current value
module axi_dac_jesd204_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (clr) begin
      // An event in the clearing cycle is not lost: it becomes the first count.
      count_reg <= inc ? WIDTH'(1) : '0;
    end else if (inc && !(&count_reg)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/axi_dac_jesd204_tx_sequencer.sv
// axi_dac_jesd204_tx_sequencer
//   Start/stop sequencer between the DMA stream and the DAC data bus.
//   Arms on cfg_arm, qualifies on link_ready (and ext_sync when enabled),
//   aligns the start to an LMFC edge plus cfg_start_delay cycles, then
//   passes DMA beats through one register stage. Missing beats in RUN are
//   replaced by zeros and counted; link loss or cfg_stop returns to IDLE.
//   Ports:
//     dac_clk, dac_rst       clock, synchronous active-high reset
//     cfg_*                  software controls (arm/stop/clear pulses,
//                            ext-sync enable, start delay)
//     dac_enable             per-channel enable, disabled lanes output zero
//     link_ready, lmfc_edge  JESD204 link status and LMFC boundary strobe
//     ext_sync               external start trigger (level)
//     dma                    DMA stream (slave side)
//     dac_data               registered samples to the framer
//     seq_state/seq_running  FSM state and RUN indicator
//     status_unf, status_link_lost, unf_count   sticky status
module axi_dac_jesd204_tx_sequencer
  import axi_dac_jesd204_pkg::*;
#(
  parameter int NUM_CHANNELS    = 1,
  parameter int DATA_PATH_WIDTH = 4,
  parameter int DELAY_WIDTH     = 8,
  parameter int UNF_CNT_WIDTH   = 16,
  localparam int CDW = 16 * DATA_PATH_WIDTH,
  localparam int DW  = CDW * NUM_CHANNELS
) (
  input  logic                     dac_clk,
  input  logic                     dac_rst,
  input  logic                     cfg_arm,
  input  logic                     cfg_stop,
  input  logic                     cfg_ext_sync_en,
  input  logic [DELAY_WIDTH-1:0]   cfg_start_delay,
  input  logic                     cfg_status_clr,
  input  logic [NUM_CHANNELS-1:0]  dac_enable,
  input  logic                     link_ready,
  input  logic                     lmfc_edge,
  input  logic                     ext_sync,
  axi_dac_jesd204_tx_sequencer_if.slave dma,
  output logic [DW-1:0]            dac_data,
  output logic [SEQ_STATE_W-1:0]   seq_state,
  output logic                     seq_running,
  output logic                     status_unf,
  output logic                     status_link_lost,
  output logic [UNF_CNT_WIDTH-1:0] unf_count
);

  seq_state_t             state_reg;
  logic [DELAY_WIDTH-1:0] delay_cnt_reg;
  logic                   seq_running_reg;
  logic                   status_unf_reg;
  logic                   status_link_lost_reg;

  logic sync_ok;
  logic link_abort;
  logic run_active;
  logic underflow;

  assign sync_ok    = link_ready && (ext_sync || !cfg_ext_sync_en);
  // cfg_stop outranks link loss, so a simultaneous stop does not flag link loss.
  assign link_abort = !cfg_stop && !link_ready && (state_reg != ST_IDLE);
  // A RUN cycle that is leaving for IDLE on this edge neither forwards data nor counts underflow.
  assign run_active = (state_reg == ST_RUN) && !cfg_stop && link_ready;
  assign underflow  = run_active && !dma.valid;

  // Sequencer FSM; seq_running is registered alongside the state.
  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      state_reg       <= ST_IDLE;
      delay_cnt_reg   <= '0;
      seq_running_reg <= 1'b0;
    end else begin
      seq_running_reg <= 1'b0;
      if (cfg_stop || link_abort) begin
        state_reg <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (cfg_arm) state_reg <= ST_ARMED;
          end
          ST_ARMED: begin
            if (sync_ok) state_reg <= ST_ALIGN;
          end
          ST_ALIGN: begin
            if (lmfc_edge) begin
              if (cfg_start_delay == '0) begin
                state_reg       <= ST_RUN;
                seq_running_reg <= 1'b1;
              end else begin
                delay_cnt_reg <= cfg_start_delay;
                state_reg     <= ST_DELAY;
              end
            end
          end
          ST_DELAY: begin
            // The loaded value N yields exactly N DELAY cycles before RUN.
            if (delay_cnt_reg <= DELAY_WIDTH'(1)) begin
              state_reg       <= ST_RUN;
              seq_running_reg <= 1'b1;
            end else begin
              delay_cnt_reg <= delay_cnt_reg - 1'b1;
            end
          end
          ST_RUN: begin
            seq_running_reg <= 1'b1;
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Sticky flags; a set in the clearing cycle wins over the clear.
  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      status_unf_reg       <= 1'b0;
      status_link_lost_reg <= 1'b0;
    end else begin
      if (underflow)           status_unf_reg <= 1'b1;
      else if (cfg_status_clr) status_unf_reg <= 1'b0;

      if (link_abort)          status_link_lost_reg <= 1'b1;
      else if (cfg_status_clr) status_link_lost_reg <= 1'b0;
    end
  end

  axi_dac_jesd204_sat_cnt #(
    .WIDTH (UNF_CNT_WIDTH)
  ) u_unf_cnt (
    .clk   (dac_clk),
    .srst  (dac_rst),
    .clr   (cfg_status_clr),
    .inc   (underflow),
    .count (unf_count)
  );

  // Data register stage, one lane per channel, zero unless a beat is consumed on an enabled lane.
  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_lane
    logic [CDW-1:0] lane_reg;

    always_ff @(posedge dac_clk) begin
      if (dac_rst) begin
        lane_reg <= '0;
      end else if (run_active && dma.valid && dac_enable[gi]) begin
        lane_reg <= dma.data[CDW*gi +: CDW];
      end else begin
        lane_reg <= '0;
      end
    end

    assign dac_data[CDW*gi +: CDW] = lane_reg;
  end

  assign dma.ready        = (state_reg == ST_RUN);
  assign seq_state        = state_reg;
  assign seq_running      = seq_running_reg;
  assign status_unf       = status_unf_reg;
  assign status_link_lost = status_link_lost_reg;

endmodule
